// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: VGA reads first, then the screen-clear sequencer,
// then ports A/B served round-robin. The VRAM has a 1-cycle registered read.
module vram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL = 'h20
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
    logic              clr_done_reg, clr_done_next;
    logic              last_b_reg, last_b_next;  // 1 = port B was served last
    logic              vga_rvalid_reg;
    logic              clr_write;
    logic [1:0]        port_gnt;
    logic [1:0]        port_we;
    logic [1:0]        port_rvalid_reg;

    assign port_we  = {b_we, a_we};
    assign a_gnt    = port_gnt[0];
    assign b_gnt    = port_gnt[1];
    assign clr_busy = (state_reg == CLEAR);
    assign clr_done = clr_done_reg;
    assign rdata    = ram_rdata;

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        clr_done_next = 1'b0;
        last_b_next   = last_b_reg;
        clr_write     = 1'b0;
        port_gnt      = 2'b00;
        ram_addr      = '0;
        ram_we        = 1'b0;
        ram_wdata     = '0;

        if (vga_req) begin
            ram_addr = vga_addr;
        end else if (state_reg == CLEAR) begin
            clr_write = 1'b1;
            ram_addr  = clr_addr_reg;
            ram_we    = 1'b1;
            ram_wdata = FILL;
        end else begin
            // On a tie, serve whichever port did not go last.
            port_gnt[0] = a_req && (!b_req || last_b_reg);
            port_gnt[1] = b_req && (!a_req || !last_b_reg);
            if (port_gnt[0]) begin
                ram_addr    = a_addr;
                ram_we      = a_we;
                ram_wdata   = a_wdata;
                last_b_next = 1'b0;
            end else if (port_gnt[1]) begin
                ram_addr    = b_addr;
                ram_we      = b_we;
                ram_wdata   = b_wdata;
                last_b_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (clr_start) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                if (clr_write) begin
                    clr_addr_next = clr_addr_reg + 1'b1;
                    if (&clr_addr_reg) begin
                        state_next    = IDLE;
                        clr_done_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_reg      <= IDLE;
            clr_addr_reg   <= '0;
            clr_done_reg   <= 1'b0;
            last_b_reg     <= 1'b1;
            vga_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clr_addr_reg   <= clr_addr_next;
            clr_done_reg   <= clr_done_next;
            last_b_reg     <= last_b_next;
            vga_rvalid_reg <= vga_req;
        end
    end

    // Read-data valid flags follow a read grant by exactly one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port_rvalid
        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                port_rvalid_reg[gi] <= 1'b0;
            end else begin
                port_rvalid_reg[gi] <= port_gnt[gi] & ~port_we[gi];
            end
        end
    end

    assign vga_rvalid = vga_rvalid_reg;
    assign a_rvalid   = port_rvalid_reg[0];
    assign b_rvalid   = port_rvalid_reg[1];

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port synchronous character/attribute VRAM between three users:
  - the VGA text renderer (fixed highest priority);
  - two generic ports A and B (CPU bus and PS/2 keyboard echo path), served round-robin.
- Contains a screen-clear sequencer that fills the whole VRAM with a fill word using cycles the VGA reader leaves free.
- Sits between the VGA timing/render logic, the CPU/keyboard datapaths and the VRAM instance in the board top level.

Parameters:
- ADDR_W, 12, VRAM address width; depth = 2**ADDR_W words.
- DATA_W, 8, VRAM word width.
- FILL, 8'h20, word written by the clear sequencer (ASCII space).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- vga_req  in  1  VGA read request.
- vga_addr  in  ADDR_W  VGA read address.
- vga_rvalid  out  1  vga read data valid on rdata.
- a_req, b_req  in  1 each  port request; held until granted.
- a_we, b_we  in  1 each  1 = write, 0 = read.
- a_addr, b_addr  in  ADDR_W each  port address.
- a_wdata, b_wdata  in  DATA_W each  port write data.
- a_gnt, b_gnt  out  1 each  access performed this cycle.
- a_rvalid, b_rvalid  out  1 each  read data valid on rdata.
- rdata  out  DATA_W  shared read data, equal to ram_rdata.
- clr_start  in  1  one-cycle pulse to start a full-screen clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last fill write.
- ram_addr  out  ADDR_W  VRAM address.
- ram_we  out  1  VRAM write enable.
- ram_wdata  out  DATA_W  VRAM write data.
- ram_rdata  in  DATA_W  VRAM read data, 1-cycle read latency.

Behaviour:
- One VRAM access per cycle.
- Grant is combinational from the current-cycle requests; ram_addr/ram_we/ram_wdata are driven combinationally for the winning user.
- Priority, evaluated every cycle:
  1. vga_req: VGA read, ram_we = 0.
  2. Clear sequencer when in CLEAR: write FILL at clr_addr.
  3. A/B round-robin.
- While clr_busy = 1, a_gnt and b_gnt stay 0 and ports wait.
- Round-robin:
  - If only one of A/B requests, that port is granted.
  - If both request, grant the port not served last.
  - The last_served register updates only on an A/B grant; it resets to B so A wins the first tie.
- Idle cycle (no grant): ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Read latency:
  - *_rvalid is registered and asserts exactly 1 cycle after a read grant: vga_rvalid <= vga_req; a_rvalid <= a_gnt & ~a_we; likewise for B.
  - Writes never produce rvalid.
  - rdata is valid only when some rvalid is 1.
- Requester contract:
  - Hold req/we/addr/wdata stable until *_gnt is seen high.
  - The next cycle may be a new request or req low.
  - A port that keeps req high after gnt is granted again (back-to-back accesses are allowed).
- Clear sequencer FSM:
  - IDLE: clr_busy = 0. On clr_start, go to CLEAR with clr_addr = 0.
  - CLEAR: clr_busy = 1.
    - Each cycle without vga_req, write FILL at clr_addr and increment clr_addr.
    - A cycle with vga_req stalls: no write, clr_addr holds.
    - When the write at clr_addr = 2**ADDR_W-1 occurs, go to IDLE and pulse clr_done for the following cycle.
  - clr_start while in CLEAR is ignored (no restart).
  - clr_start in the cycle clr_done is high starts a new clear.
- Reset (any state, including mid-clear):
  - FSM goes to IDLE, clr_addr = 0, last_served = B.
  - All rvalids = 0, clr_busy = 0, clr_done = 0.
  - The interrupted clear is abandoned; already-written words are not restored.
- Simultaneous events: VGA, clear and both ports requesting in one cycle gives VGA only. The others hold and the RR pointer is unchanged.
- Full clear with no VGA traffic takes exactly 2**ADDR_W cycles from the cycle after clr_start to the last write.

Test Plan:
1. Reset then idle: all outputs 0, ram_we = 0. Assert a_req read addr 0x010 -> a_gnt same cycle, a_rvalid next cycle with rdata = mem[0x010].
2. a_req and b_req both held high 4 cycles, no VGA -> grants A,B,A,B. Write A 0x55 @0x001 then read back -> 0x55.
3. vga_req high with a_req high 3 cycles -> a_gnt = 0 for 3 cycles; vga_rvalid 1 for 3 cycles (each 1 cycle after its request); a_gnt in cycle 4.
4. ADDR_W = 4, clr_start, vga_req high every other cycle -> 16 FILL writes to 0x0..0xF in order, clr_busy high 31 cycles, single clr_done pulse. a_req during the clear is not granted until clr_busy falls.
5. clr_start pulsed again mid-clear -> no restart; addresses continue sequentially; exactly one clr_done.
6. RESET asserted at clr_addr = 5 -> next cycle clr_busy = 0, clr_done = 0, no writes. A following clr_start begins at address 0.
